// File: rtl/repetition_pattern_gen.sv
// Stimulus source for the repetition monitors: a run of `a`, or `a` then N spaced `b` pulses.
// Define REPGEN_ASSERT_EN to compile concurrent assertions on the block's own outputs.
module repetition_pattern_gen #(
  parameter int CNT_W      = 4,
  parameter int A_TO_B_MIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] gap,
  output logic             busy,
  output logic             done,
  output logic             a,
  output logic             b
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    A_PULSE,
    A_WAIT,
    B_PULSE,
    B_GAP,
    FIN
  } state_t;

  // Timer must hold gap+1 without wrapping and also the a-to-b wait length.
  localparam int TMR_W = (CNT_W + 1 > 4) ? CNT_W + 1 : 4;
  localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(A_TO_B_MIN - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [CNT_W-1:0] REM_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             a_q, a_d;
  logic             b_q, b_d;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    tmr_d   = tmr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d = count;
          gap_d = gap;
          if (count == '0)   state_d = FIN;
          else if (!mode)    state_d = RUN;
          else               state_d = A_PULSE;
        end
      end
      RUN: begin
        rem_d = rem_q - REM_ONE;
        if (rem_q == REM_ONE) state_d = FIN;
      end
      A_PULSE: begin
        // With a minimum spacing of one cycle there is no wait phase at all.
        if (A_TO_B_MIN > 1) begin
          tmr_d   = WAIT_LOAD;
          state_d = A_WAIT;
        end else begin
          state_d = B_PULSE;
        end
      end
      A_WAIT: begin
        if (tmr_q == TMR_ONE) state_d = B_PULSE;
        else                  tmr_d   = tmr_q - TMR_ONE;
      end
      B_PULSE: begin
        rem_d = rem_q - REM_ONE;
        if (rem_q == REM_ONE) begin
          state_d = FIN;
        end else begin
          tmr_d   = TMR_W'(gap_q) + TMR_ONE;
          state_d = B_GAP;
        end
      end
      B_GAP: begin
        if (tmr_q == TMR_ONE) state_d = B_PULSE;
        else                  tmr_d   = tmr_q - TMR_ONE;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the block registered.
    a_d    = (state_d == RUN) || (state_d == A_PULSE);
    b_d    = (state_d == B_PULSE);
    done_d = (state_d == FIN);
    busy_d = (state_d != IDLE) && (state_d != FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      tmr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      tmr_q   <= tmr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign a    = a_q;
  assign b    = b_q;

`ifdef REPGEN_ASSERT_EN
  a_then_no_b: assert property (@(posedge clk) disable iff (rst) a |-> !b [*A_TO_B_MIN]);
  b_spaced:    assert property (@(posedge clk) disable iff (rst) b |=> !b);
  a_b_mutex:   assert property (@(posedge clk) disable iff (rst) !(a && b));
  done_single: assert property (@(posedge clk) disable iff (rst) done |=> !done);
  done_idle:   assert property (@(posedge clk) disable iff (rst) done |-> !busy);
`else
`endif

endmodule

// File: tb/tb_repetition_pattern_gen.sv
// Directed bench for repetition_pattern_gen: per-cycle output traces compared against hand-built masks.
// Bit k of a trace holds the output in the k-th cycle after the edge that accepts start.
module tb_repetition_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic [3:0] count;
  logic [3:0] gap;
  logic       busy;
  logic       done;
  logic       a;
  logic       b;

  int checkCount = 0;
  int failCount  = 0;

  logic [63:0] aTr, bTr, doneTr, busyTr;

  repetition_pattern_gen #(
    .CNT_W      (4),
    .A_TO_B_MIN (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .count (count),
    .gap   (gap),
    .busy  (busy),
    .done  (done),
    .a     (a),
    .b     (b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Launches one pattern and records ncyc cycles; startMask/rstMask bit k drives the
  // edge that ends cycle k, which lets a test poke start or rst mid-pattern.
  task automatic applyStimulus(input logic m, input logic [3:0] cnt, input logic [3:0] g,
                               input int ncyc, input logic [63:0] startMask,
                               input logic [63:0] rstMask);
    @(negedge clk);
    mode  = m;
    count = cnt;
    gap   = g;
    start = 1'b1;
    aTr = '0; bTr = '0; doneTr = '0; busyTr = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #1;
      aTr[k]    = a;
      bTr[k]    = b;
      doneTr[k] = done;
      busyTr[k] = busy;
      start     = startMask[k];
      rst       = rstMask[k];
    end
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic checkTraces(input string tag, input logic [63:0] expA, input logic [63:0] expB,
                             input logic [63:0] expDone, input logic [63:0] expBusy);
    checkOutput({tag, "_a"},    aTr,    expA);
    checkOutput({tag, "_b"},    bTr,    expB);
    checkOutput({tag, "_done"}, doneTr, expDone);
    checkOutput({tag, "_busy"}, busyTr, expBusy);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    mode  = 1'b0;
    count = 4'd3;
    gap   = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_a",    {63'd0, a},    64'd0);
    checkOutput("rst_b",    {63'd0, b},    64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);

    // Consecutive run of 5: a in 1..5, done in 6.
    applyStimulus(1'b0, 4'd5, 4'd0, 10, 64'd0, 64'd0);
    checkTraces("cons5", 64'h3E, 64'h0, 64'h40, 64'h3E);

    // Goto, one b: a at 1, b at 5, done at 6.
    applyStimulus(1'b1, 4'd1, 4'd0, 10, 64'd0, 64'd0);
    checkTraces("goto1", 64'h2, 64'h20, 64'h40, 64'h3E);

    // Goto, two b with gap 0: b at 5 and 7, done at 8.
    applyStimulus(1'b1, 4'd2, 4'd0, 12, 64'd0, 64'd0);
    checkTraces("goto2g0", 64'h2, 64'hA0, 64'h100, 64'hFE);

    // Gap 3: b at 5 and 10, done at 11; a start poke at cycle 2 must be ignored.
    applyStimulus(1'b1, 4'd2, 4'd3, 16, 64'h4, 64'd0);
    checkTraces("goto2g3", 64'h2, 64'h420, 64'h800, 64'h7FE);

    // Empty patterns: done at cycle 1 only, nothing else.
    applyStimulus(1'b0, 4'd0, 4'd0, 6, 64'd0, 64'd0);
    checkTraces("cnt0_cons", 64'h0, 64'h0, 64'h2, 64'h0);
    applyStimulus(1'b1, 4'd0, 4'd5, 6, 64'd0, 64'd0);
    checkTraces("cnt0_goto", 64'h0, 64'h0, 64'h2, 64'h0);

    // Max gap: b at 5 and 22 (16 low cycles between), done at 23.
    applyStimulus(1'b1, 4'd2, 4'd15, 26, 64'd0, 64'd0);
    checkTraces("gap15", 64'h2, 64'h400020, 64'h800000, 64'h7FFFFE);

    // Start held through cycle 4: second pattern only begins after one idle cycle.
    applyStimulus(1'b0, 4'd2, 4'd0, 10, 64'h1E, 64'd0);
    checkTraces("b2b", 64'h66, 64'h0, 64'h88, 64'h66);

    // Reset during the first gap: cycle 7 onward everything is low and no done appears.
    applyStimulus(1'b1, 4'd3, 4'd3, 20, 64'd0, 64'h40);
    checkTraces("abort", 64'h2, 64'h20, 64'h0, 64'h7E);

    applyStimulus(1'b0, 4'd2, 4'd0, 8, 64'd0, 64'd0);
    checkTraces("post_abort", 64'h6, 64'h0, 64'h8, 64'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/repetition_pattern_gen.md
# repetition_pattern_gen

Synthesizable stimulus source for the repetition examples. It drives the `a` and `b` observation signals with either a consecutive run of `a`, or an `a` pulse followed by N goto-style `b` pulses. Every waveform it produces obeys the spacing rules the goto checks place on their inputs: `a |-> !b [*4]` and `b |=> !b`. It sits in front of the consecutive and goto repetition monitors, so the covers can be hit in simulation without formal assumptions.

## Interface
Parameters:
- `CNT_W`, default 4: width of the `count` and `gap` inputs and of the internal counters.
- `A_TO_B_MIN`, default 4: number of cycles, starting with the `a` cycle, during which `b` is held low. Legal range is 1..15.

Ports:
- `clk` input 1: sole clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a pattern; sampled only in IDLE.
- `mode` input 1: 0 = CONSECUTIVE (run of `a`), 1 = GOTO (`a` then `b` pulses); latched on accepted `start`.
- `count` input `CNT_W`: run length (CONSECUTIVE) or number of `b` pulses (GOTO); latched on accepted `start`.
- `gap` input `CNT_W`: extra low cycles between consecutive `b` pulses in GOTO; latched on accepted `start`.
- `busy` output 1: high while a pattern is in progress.
- `done` output 1: one-cycle pulse when a pattern completes.
- `a` output 1: generated `a`.
- `b` output 1: generated `b`.

## Operation
- All outputs are registered. Reset value of `busy`, `done`, `a` and `b` is 0; state is IDLE; counters are 0.
- States: IDLE, RUN, A_PULSE, A_WAIT, B_PULSE, B_GAP, FIN.
- IDLE with `start`=1: latch `mode`, `count` and `gap`.
  - `count`=0 → FIN (empty pattern).
  - `mode`=0 → RUN.
  - `mode`=1 → A_PULSE.
- RUN: `a`=1 for exactly `count` cycles, then FIN.
- A_PULSE: `a`=1 for one cycle, then A_WAIT.
- A_WAIT: `a`=0, `b`=0 for `A_TO_B_MIN`-1 cycles, then B_PULSE.
- B_PULSE: `b`=1 for one cycle, and the remaining-pulse counter decrements.
  - Remaining = 0 → FIN.
  - Otherwise → B_GAP.
- B_GAP: `b`=0 for `gap`+1 cycles, then B_PULSE.
- FIN: `done`=1, `busy`=0 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE and FIN.
- `start` is ignored outside IDLE. It is not queued.
- `a` and `b` are never high in the same cycle.
- Counter arithmetic is unsigned `CNT_W`-bit. `gap`+1 is computed `CNT_W`+1 bits wide, so `gap` = all-ones gives 2^`CNT_W` low cycles with no wrap.
- `rst` in any state: on the next edge, state returns to IDLE and all outputs go to 0. No `done` is generated for the aborted pattern.
- `rst` and `start` high together: `rst` wins and `start` is dropped.

## Timing
- Let edge t be the edge that samples `start`=1 in IDLE.
- CONSECUTIVE, `count`=N≥1:
  - `a`=1 in cycles t+1 .. t+N.
  - `done` in cycle t+N+1.
  - The earliest new `start` is accepted at the edge that ends cycle t+N+2, i.e. IDLE is reached one cycle after `done`.
- GOTO, `count`=N≥1, `gap`=G:
  - `a` in cycle t+1.
  - First `b` in cycle t+1+`A_TO_B_MIN`.
  - Each later `b` follows the previous one by G+2 cycles.
  - `done` is in the cycle after the last `b`.
- `count`=0, either mode: `done` in cycle t+1, with no `a`, no `b` and no `busy`.
- Back-to-back: IDLE lasts at least one cycle, so `done` and the next `a` are never adjacent to the previous pattern's last activity.

## Configuration
- `REPGEN_ASSERT_EN` defined: the block contains concurrent assertions on its own outputs, all disabled during `rst`:
  - `a |-> !b [*A_TO_B_MIN]`
  - `b |=> !b`
  - `!(a && b)`
  - `done |=> !done`
  - `done |-> !busy`
- `REPGEN_ASSERT_EN` undefined: no assertion code is compiled. Functional behaviour is identical in both cases.

## Test plan
- CONSECUTIVE, `count`=5, `start` at edge 10 → `a` high cycles 11–15; `done` cycle 16; the consecutive `a [*5]` monitor fires once.
- GOTO, `count`=1, `A_TO_B_MIN`=4, start at edge 10 → `a` cycle 11; `b` cycle 15; `done` cycle 16; `a ##1 b[->1]` covered.
- GOTO, `count`=2, `gap`=0 → `b` at cycles 15 and 17; `done` 18. With `gap`=3 → `b` at 15 and 20; `done` 21. `b |=> !b` holds in both runs.
- `count`=0 in both modes → `done` one cycle after start, with `a`, `b` and `busy` low throughout. `start` pulsed during `busy` → ignored, so no second pattern and no extra `done`.
- `rst` asserted in B_GAP of a `count`=3 GOTO run → all outputs 0 next cycle; no `done`. A new CONSECUTIVE `count`=2 start afterwards → `a` for exactly 2 cycles.
- `gap`=15 with `CNT_W`=4 → 16 low cycles between `b` pulses; no counter wrap.
